// File: rtl/jtcop_irqctl_pkg.sv
// Shared constants for the jtcop interrupt controller.
//
// Contents:
//   IPL_NONE  IPLn value presented when no enabled source is pending
//   LVL_W     width of one IPL level field
//   NIRQ_MAX  largest supported number of interrupt sources
//   IDX_W     width of a channel index (covers NIRQ_MAX channels)
//   to_ipln   converts a level to the active-low IPLn encoding
package jtcop_irqctl_pkg;

    localparam logic [2:0]  IPL_NONE = 3'b111;
    localparam int unsigned LVL_W    = 3;
    localparam int unsigned NIRQ_MAX = 8;
    localparam int unsigned IDX_W    = 3;

    // 68000 IPL pins are active low: level 6 is presented as 3'b001.
    function automatic logic [LVL_W-1:0] to_ipln(input logic [LVL_W-1:0] lvl);
        return ~lvl;
    endfunction

endpackage

// File: rtl/jtcop_irq_prienc.sv
// Combinational priority encoder for the jtcop interrupt controller.
//
// Picks the requesting channel with the highest IPL level; on equal levels the lowest
// channel index wins. Channels whose level is 0 can never win, so they never reach IPLn.
//
// Parameters:
//   NIRQ  number of channels
//   LVL   packed 3-bit level per channel, channel 0 in the LSBs
// Ports:
//   req    in   NIRQ   pending & mask
//   valid  out  1      a channel with non-zero level is requesting
//   idx    out  3      index of the winning channel (0 when !valid)
//   lvl    out  3      level of the winning channel (0 when !valid)
module jtcop_irq_prienc
    import jtcop_irqctl_pkg::*;
#(
    parameter int unsigned           NIRQ = 4,
    parameter logic [LVL_W*NIRQ-1:0] LVL  = '0
) (
    input  logic [NIRQ-1:0]  req,
    output logic             valid,
    output logic [IDX_W-1:0] idx,
    output logic [LVL_W-1:0] lvl
);

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        lvl   = '0;
        // Strict '>' keeps the earliest (lowest index) channel on a tie and, since lvl
        // starts at 0, silently skips channels configured with level 0.
        for (int i = 0; i < NIRQ; i++) begin
            if (req[i] && (LVL[i*LVL_W +: LVL_W] > lvl)) begin
                valid = 1'b1;
                idx   = i[IDX_W-1:0];
                lvl   = LVL[i*LVL_W +: LVL_W];
            end
        end
    end

endmodule

// File: rtl/jtcop_irqctl.sv
// Parametrised 68000 interrupt controller for the main CPU.
//
// Each of NIRQ sources has its own IPL level, edge/level mode, polarity, IACK auto-clear
// enable and mask bit. The highest-level enabled pending source drives the registered
// active-low IPLn. A rising edge of iack whose level matches the presented IPL clears the
// winning channel when that channel has auto-clear enabled.
//
// Optional feature: define JTCOP_IRQ_SYNC_EN to pass irq_in through a 2-flop synchroniser
// (input edge to IPLn latency 4 clk instead of 2).
//
// Parameters:
//   NIRQ      number of sources (1..8)
//   LVL       packed 3-bit level per channel, ch0 in LSBs; 0 never asserts
//   EDGE      1: edge-latched pending, 0: pending follows the input
//   POL       1: input active low
//   AUTOCLR   1: matching IACK clears the channel's pending bit
//   MASK_RST  mask value after reset (1 = enabled)
// Ports:
//   clk       in   1     system clock
//   rstn      in   1     asynchronous active-low reset
//   irq_in    in   NIRQ  raw interrupt inputs
//   clr       in   NIRQ  one-cycle clear strobes
//   mask_we   in   1     mask register write strobe
//   mask_din  in   NIRQ  mask write data
//   iack      in   1     CPU interrupt acknowledge cycle active
//   iack_lvl  in   3     level being acknowledged
//   IPLn      out  3     registered active-low level to the CPU
//   pending   out  NIRQ  pending bits before masking
//   mask      out  NIRQ  current mask register
module jtcop_irqctl
    import jtcop_irqctl_pkg::*;
#(
    parameter int unsigned           NIRQ     = 4,
    parameter logic [LVL_W*NIRQ-1:0] LVL      = {3'd4, 3'd5, 3'd6, 3'd6},
    parameter logic [NIRQ-1:0]       EDGE     = 4'b1111,
    parameter logic [NIRQ-1:0]       POL      = 4'b0000,
    parameter logic [NIRQ-1:0]       AUTOCLR  = 4'b1111,
    parameter logic [NIRQ-1:0]       MASK_RST = 4'b1111
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [NIRQ-1:0]  irq_in,
    input  logic [NIRQ-1:0]  clr,
    input  logic             mask_we,
    input  logic [NIRQ-1:0]  mask_din,
    input  logic             iack,
    input  logic [LVL_W-1:0] iack_lvl,
    output logic [LVL_W-1:0] IPLn,
    output logic [NIRQ-1:0]  pending,
    output logic [NIRQ-1:0]  mask
);

    logic [NIRQ-1:0]  irq_s;
    logic [NIRQ-1:0]  act;
    logic [NIRQ-1:0]  act_q;
    logic [NIRQ-1:0]  rise;
    logic [NIRQ-1:0]  pending_d, pending_q;
    logic [NIRQ-1:0]  mask_q;
    logic [NIRQ-1:0]  ack_clr;
    logic             iack_q;
    logic             iack_rise;
    logic             ack_hit;
    logic [LVL_W-1:0] ipl_d, ipl_q;
    logic             win_valid;
    logic [IDX_W-1:0] win_idx;
    logic [LVL_W-1:0] win_lvl;

    // ------------------------------------------------------------------------------------
    // Optional input synchroniser
    // ------------------------------------------------------------------------------------
`ifdef JTCOP_IRQ_SYNC_EN
    logic [NIRQ-1:0] irq_meta_q, irq_sync_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            irq_meta_q <= '0;
            irq_sync_q <= '0;
        end else begin
            irq_meta_q <= irq_in;
            irq_sync_q <= irq_meta_q;
        end
    end

    assign irq_s = irq_sync_q;
`else
    // Inputs are assumed to be already synchronous to clk.
    assign irq_s = irq_in;
`endif

    // ------------------------------------------------------------------------------------
    // Polarity and edge detection
    // ------------------------------------------------------------------------------------
    assign act  = irq_s ^ POL;
    // History resets to 0, so an input already active at reset release counts as an edge.
    assign rise = act & ~act_q;

    // ------------------------------------------------------------------------------------
    // Priority selection over enabled pending sources
    // ------------------------------------------------------------------------------------
    jtcop_irq_prienc #(
        .NIRQ (NIRQ),
        .LVL  (LVL)
    ) u_prienc (
        .req   (pending_q & mask_q),
        .valid (win_valid),
        .idx   (win_idx),
        .lvl   (win_lvl)
    );

    // ------------------------------------------------------------------------------------
    // IACK auto-clear
    // ------------------------------------------------------------------------------------
    // Only the first cycle of an acknowledge counts, so a held iack clears one channel.
    assign iack_rise = iack & ~iack_q;
    assign ack_hit   = iack_rise && win_valid && (iack_lvl == to_ipln(ipl_q));

    always_comb begin
        ack_clr = '0;
        for (int i = 0; i < NIRQ; i++) begin
            ack_clr[i] = ack_hit && (win_idx == i[IDX_W-1:0]) && AUTOCLR[i];
        end
    end

    // ------------------------------------------------------------------------------------
    // Pending next state
    // ------------------------------------------------------------------------------------
    always_comb begin
        pending_d = pending_q;
        for (int i = 0; i < NIRQ; i++) begin
            if (EDGE[i]) begin
                // A new edge beats a simultaneous clear so no interrupt is lost.
                if (rise[i]) begin
                    pending_d[i] = 1'b1;
                end else if (clr[i] || ack_clr[i]) begin
                    pending_d[i] = 1'b0;
                end
            end else begin
                pending_d[i] = act[i];
            end
        end
    end

    assign ipl_d = win_valid ? to_ipln(win_lvl) : IPL_NONE;

    // ------------------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            act_q     <= '0;
            pending_q <= '0;
            mask_q    <= MASK_RST;
            iack_q    <= 1'b0;
            ipl_q     <= IPL_NONE;
        end else begin
            act_q     <= act;
            pending_q <= pending_d;
            iack_q    <= iack;
            ipl_q     <= ipl_d;
            if (mask_we) begin
                mask_q <= mask_din;
            end
        end
    end

    assign IPLn    = ipl_q;
    assign pending = pending_q;
    assign mask    = mask_q;

endmodule

// File: tb/tb_jtcop_irqctl.sv
// Self-checking bench for jtcop_irqctl with its default parameters. Directed scenarios use
// constant expectations; a randomized phase compares against a behavioural model.
// Define JTCOP_IRQ_SYNC_EN for both bench and RTL to exercise the synchronised build.
module tb_jtcop_irqctl;

    localparam int unsigned NIRQ     = 4;
    localparam logic [11:0] LVL      = {3'd4, 3'd5, 3'd6, 3'd6};
    localparam logic [3:0]  EDGE     = 4'b1111;
    localparam logic [3:0]  POL      = 4'b0000;
    localparam logic [3:0]  AUTOCLR  = 4'b1111;
    localparam logic [3:0]  MASK_RST = 4'b1111;
`ifdef JTCOP_IRQ_SYNC_EN
    localparam int LAT  = 4;
    localparam bit SYNC = 1'b1;
`else
    localparam int LAT  = 2;
    localparam bit SYNC = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic [NIRQ-1:0] irq_in = '0;
    logic [NIRQ-1:0] clr = '0;
    logic            mask_we = 1'b0;
    logic [NIRQ-1:0] mask_din = '0;
    logic            iack = 1'b0;
    logic [2:0]      iack_lvl = '0;
    logic [2:0]      ipln;
    logic [NIRQ-1:0] pending;
    logic [NIRQ-1:0] mask;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [NIRQ-1:0] m_pend, m_mask, m_hist, m_s1, m_s2;
    logic [2:0]      m_ipl;
    logic            m_iack_prev;

    jtcop_irqctl #(
        .NIRQ     (NIRQ),
        .LVL      (LVL),
        .EDGE     (EDGE),
        .POL      (POL),
        .AUTOCLR  (AUTOCLR),
        .MASK_RST (MASK_RST)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .irq_in   (irq_in),
        .clr      (clr),
        .mask_we  (mask_we),
        .mask_din (mask_din),
        .iack     (iack),
        .iack_lvl (iack_lvl),
        .IPLn     (ipln),
        .pending  (pending),
        .mask     (mask)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] lvl_of(input int ch);
        return LVL[ch*3 +: 3];
    endfunction

    // Highest level first, then lowest channel; level 0 never wins.
    function automatic int winner(input logic [NIRQ-1:0] req);
        for (int lv = 7; lv >= 1; lv--) begin
            for (int i = 0; i < NIRQ; i++) begin
                if (req[i] && (lvl_of(i) == lv[2:0])) return i;
            end
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_pend      = '0;
        m_mask      = MASK_RST;
        m_hist      = '0;
        m_s1        = '0;
        m_s2        = '0;
        m_ipl       = 3'b111;
        m_iack_prev = 1'b0;
    endtask

    // One clock edge of the specified behaviour, using the inputs currently applied.
    task automatic model_tick();
        logic [NIRQ-1:0] raw, act, nxt;
        int w;
        if (SYNC) begin
            raw  = m_s2;
            m_s2 = m_s1;
            m_s1 = irq_in;
        end else begin
            raw = irq_in;
        end
        act = raw ^ POL;
        w   = winner(m_pend & m_mask);
        nxt = m_pend;
        for (int i = 0; i < NIRQ; i++) begin
            if (EDGE[i]) begin
                if (act[i] && !m_hist[i]) nxt[i] = 1'b1;
                else if (clr[i]) nxt[i] = 1'b0;
                else if (iack && !m_iack_prev && (w == i) && (iack_lvl == ~m_ipl) && AUTOCLR[i])
                    nxt[i] = 1'b0;
            end else begin
                nxt[i] = act[i];
            end
        end
        m_ipl       = (w < 0) ? 3'b111 : ~lvl_of(w);
        m_pend      = nxt;
        if (mask_we) m_mask = mask_din;
        m_hist      = act;
        m_iack_prev = iack;
    endtask

    task automatic step();
        @(posedge clk);
        model_tick();
        #1;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic test_reset();
        model_reset();
        #12;
        checks++;
        if (ipln !== 3'b111) begin
            errors++; $display("FAIL reset_ipl: got %b want 111", ipln);
        end
        checks++;
        if (pending !== 4'b0000 || mask !== MASK_RST) begin
            errors++; $display("FAIL reset_regs: pending %b mask %b want 0000 %b",
                               pending, mask, MASK_RST);
        end
        rstn = 1'b1;
        step();
        checks++;
        if (ipln !== 3'b111) begin
            errors++; $display("FAIL idle_ipl: got %b want 111", ipln);
        end
        // Mask ch1, hold ch2 active, then reset in the middle of the interrupt.
        mask_din = 4'b1101; mask_we = 1'b1;
        step();
        mask_we = 1'b0;
        irq_in  = 4'b0100;
        steps(LAT);
        checks++;
        if (ipln !== 3'b010 || mask !== 4'b1101) begin
            errors++; $display("FAIL pre_reset: ipl %b mask %b want 010 1101", ipln, mask);
        end
        rstn = 1'b0;
        #2;
        model_reset();
        checks++;
        if (ipln !== 3'b111 || pending !== 4'b0000 || mask !== MASK_RST) begin
            errors++; $display("FAIL async_reset: ipl %b pending %b mask %b want 111 0000 %b",
                               ipln, pending, mask, MASK_RST);
        end
        rstn = 1'b1;
        // Input still active at release: history 0 makes it an edge.
        steps(LAT - 1);
        checks++;
        if (pending !== 4'b0100) begin
            errors++; $display("FAIL release_edge: pending %b want 0100", pending);
        end
        step();
        checks++;
        if (ipln !== 3'b010) begin
            errors++; $display("FAIL release_ipl: got %b want 010", ipln);
        end
        irq_in = '0; clr = 4'b0100;
        step();
        clr = '0;
        step();
        checks++;
        if (ipln !== 3'b111 || pending !== 4'b0000) begin
            errors++; $display("FAIL release_clr: ipl %b pending %b want 111 0000", ipln, pending);
        end
    endtask

    task automatic test_single();
        irq_in = 4'b0001;
        step();
        irq_in = '0;
        for (int k = 1; k < LAT; k++) begin
            checks++;
            if (ipln !== 3'b111) begin
                errors++; $display("FAIL single_early: cycle %0d got %b want 111", k, ipln);
            end
            step();
        end
        checks++;
        if (ipln !== 3'b001 || pending !== 4'b0001) begin
            errors++; $display("FAIL single_ipl: ipl %b pending %b want 001 0001", ipln, pending);
        end
        clr = 4'b0001;
        step();
        clr = '0;
        checks++;
        if (ipln !== 3'b001 || pending !== 4'b0000) begin
            errors++; $display("FAIL clr_first: ipl %b pending %b want 001 0000", ipln, pending);
        end
        step();
        checks++;
        if (ipln !== 3'b111) begin
            errors++; $display("FAIL clr_ipl: got %b want 111", ipln);
        end
    endtask

    task automatic test_priority();
        irq_in = 4'b0101;
        step();
        irq_in = '0;
        steps(LAT - 1);
        checks++;
        if (ipln !== 3'b001) begin
            errors++; $display("FAIL prio_hi: got %b want 001", ipln);
        end
        clr = 4'b0001;
        step();
        clr = '0;
        step();
        checks++;
        if (ipln !== 3'b010) begin
            errors++; $display("FAIL prio_next: got %b want 010", ipln);
        end
        clr = 4'b0100;
        step();
        clr = '0;
        step();
        checks++;
        if (ipln !== 3'b111) begin
            errors++; $display("FAIL prio_none: got %b want 111", ipln);
        end
    endtask

    task automatic test_iack();
        irq_in = 4'b0101;
        step();
        irq_in = '0;
        steps(LAT - 1);
        iack = 1'b1; iack_lvl = 3'd5;
        step();
        checks++;
        if (pending !== 4'b0101) begin
            errors++; $display("FAIL iack_mismatch: pending %b want 0101", pending);
        end
        iack = 1'b0;
        step();
        iack = 1'b1; iack_lvl = 3'd6;
        step();
        checks++;
        if (pending !== 4'b0100) begin
            errors++; $display("FAIL iack_clear: pending %b want 0100", pending);
        end
        steps(2);
        checks++;
        if (pending !== 4'b0100 || ipln !== 3'b010) begin
            errors++; $display("FAIL iack_held: pending %b ipl %b want 0100 010", pending, ipln);
        end
        iack = 1'b0;
        step();
        // Equal levels on ch0 and ch1: acknowledge must take ch0 only.
        irq_in = 4'b0011;
        step();
        irq_in = '0;
        steps(LAT - 1);
        checks++;
        if (ipln !== 3'b001 || pending !== 4'b0111) begin
            errors++; $display("FAIL tie_setup: ipl %b pending %b want 001 0111", ipln, pending);
        end
        iack = 1'b1; iack_lvl = 3'd6;
        step();
        iack = 1'b0;
        checks++;
        if (pending !== 4'b0110) begin
            errors++; $display("FAIL tie_lowidx: pending %b want 0110", pending);
        end
        clr = 4'b1111;
        step();
        clr = '0;
        step();
        checks++;
        if (ipln !== 3'b111 || pending !== 4'b0000) begin
            errors++; $display("FAIL iack_cleanup: ipl %b pending %b want 111 0000", ipln, pending);
        end
    endtask

    task automatic test_mask();
        mask_din = 4'b0000; mask_we = 1'b1;
        step();
        mask_we = 1'b0;
        checks++;
        if (mask !== 4'b0000) begin
            errors++; $display("FAIL mask_write: got %b want 0000", mask);
        end
        irq_in = 4'b0010;
        step();
        irq_in = '0;
        steps(LAT);
        checks++;
        if (pending !== 4'b0010 || ipln !== 3'b111) begin
            errors++; $display("FAIL masked: pending %b ipl %b want 0010 111", pending, ipln);
        end
        mask_din = 4'b1111; mask_we = 1'b1;
        step();
        mask_we = 1'b0;
        checks++;
        if (mask !== 4'b1111 || ipln !== 3'b111) begin
            errors++; $display("FAIL unmask_first: mask %b ipl %b want 1111 111", mask, ipln);
        end
        step();
        checks++;
        if (ipln !== 3'b001) begin
            errors++; $display("FAIL unmask_ipl: got %b want 001", ipln);
        end
        clr = 4'b0010;
        step();
        clr = '0;
        step();
    endtask

    task automatic test_set_wins();
        irq_in = 4'b0001;
        steps(LAT - 2);
        clr = 4'b0001;
        step();
        clr = '0;
        checks++;
        if (pending[0] !== 1'b1) begin
            errors++; $display("FAIL set_wins: pending[0] %b want 1", pending[0]);
        end
        // Input still high, no new edge: clear must now take effect.
        clr = 4'b0001;
        step();
        clr = '0;
        checks++;
        if (pending[0] !== 1'b0) begin
            errors++; $display("FAIL clr_no_edge: pending[0] %b want 0", pending[0]);
        end
        irq_in = '0;
        steps(LAT + 1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            irq_in   = 4'($urandom_range(0, 15));
            clr      = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            mask_we  = ($urandom_range(0, 15) == 0);
            mask_din = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) iack = ~iack;
            iack_lvl = ($urandom_range(0, 1) == 1) ? ~m_ipl : 3'($urandom_range(0, 7));
            step();
            checks++;
            if (ipln !== m_ipl || pending !== m_pend || mask !== m_mask) begin
                errors++;
                $display("FAIL random %0d: ipl %b pend %b mask %b want %b %b %b",
                         n, ipln, pending, mask, m_ipl, m_pend, m_mask);
            end
        end
        irq_in = '0; clr = '0; mask_we = 1'b0; iack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_iack();
        test_mask();
        test_set_wins();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
